// File: rtl/ad5543_sched.sv
// ad5543_sched: sample-rate scheduler and 2-way round-robin arbiter feeding the
//    AD5543 DAC driver. A period timer paces updates. Each tick grants one of two
//    AXI-stream sources, takes one sample and presents it on a single AXI-stream master.
// Latency: tick at cycle t -> ARB at t+1 -> m_axis_tvalid at t+2.
// Backpressure: m_axis_tvalid/tdata hold until m_axis_tready. Ticks that arrive while
//    busy are dropped and flagged on overrun. Sources see tready only in the ARB cycle.
// Ports:
//    s_axis_aclk / s_axis_areset      clock, synchronous active-high reset
//    en, period                       scheduler enable, sample period in clocks (0,1 = every clock)
//    s0_axis_*, s1_axis_*             two sample sources (slave side)
//    m_axis_*                         sample stream to the DAC driver (master side)
//    grant_id, underrun, overrun      last granted source, one-cycle status pulses
// Build option: define AD5543_SCHED_REPEAT_EN so that an underrun re-presents the last
//    sample (0 before the first accepted one) instead of skipping the update.

module ad5543_sched #(
   parameter int DW = 16,
   parameter int PW = 16
) (
   input  logic          s_axis_aclk,
   input  logic          s_axis_areset,
   input  logic          en,
   input  logic [PW-1:0] period,
   input  logic          s0_axis_tvalid,
   output logic          s0_axis_tready,
   input  logic [DW-1:0] s0_axis_tdata,
   input  logic          s1_axis_tvalid,
   output logic          s1_axis_tready,
   input  logic [DW-1:0] s1_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic [DW-1:0] m_axis_tdata,
   output logic          grant_id,
   output logic          underrun,
   output logic          overrun
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARB  = 2'd1;
   localparam logic [1:0] SEND = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] cnt;
   logic [PW-1:0] last_cnt;
   logic          tick;
   logic          prio;      // source that wins when both are valid
   logic          any_vld;
   logic          win;
   logic [DW-1:0] win_dat;

   // period 0 and 1 both collapse to "every clock"; period is re-read on every compare
   assign last_cnt = (period == '0) ? '0 : period - PW'(1);
   assign tick     = en && (cnt == last_cnt);

   always_comb begin
      any_vld = s0_axis_tvalid || s1_axis_tvalid;
      if (s0_axis_tvalid && s1_axis_tvalid)
         win = prio;
      else
         win = s1_axis_tvalid;
      win_dat = win ? s1_axis_tdata : s0_axis_tdata;
   end

   // Ready is offered to the winner only during ARB, so a handshake always happens
   // in ARB whenever some source is valid.
   assign s0_axis_tready = (state == ARB) && any_vld && !win;
   assign s1_axis_tready = (state == ARB) && any_vld && win;
   assign m_axis_tvalid  = (state == SEND);

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         cnt          <= '0;
         state        <= IDLE;
         m_axis_tdata <= '0;
         grant_id     <= 1'b0;
         underrun     <= 1'b0;
         overrun      <= 1'b0;
         prio         <= 1'b0;
      end else begin
         underrun <= 1'b0;
         // the tick is lost when the FSM is busy; the timer itself keeps running
         overrun  <= tick && (state != IDLE);

         if (!en || tick)
            cnt <= '0;
         else
            cnt <= cnt + PW'(1);

         case (state)
            IDLE: begin
               if (tick)
                  state <= ARB;
            end
            ARB: begin
               if (any_vld) begin
                  m_axis_tdata <= win_dat;
                  grant_id     <= win;
                  prio         <= !win;
                  state        <= SEND;
               end else begin
                  underrun <= 1'b1;
`ifdef AD5543_SCHED_REPEAT_EN
                  state    <= SEND;
`else
                  state    <= IDLE;
`endif
               end
            end
            SEND: begin
               // completes even if en has dropped: tvalid is never withdrawn early
               if (m_axis_tready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad5543_sched.sv
// tb_ad5543_sched: scoreboard bench for ad5543_sched. Expected samples are queued when
//    a scenario is set up and compared on every m_axis handshake. Timer pacing, latency,
//    underrun/overrun pulses, stall stability and reset are checked as well.
// Runs with or without AD5543_SCHED_REPEAT_EN defined.

module tb_ad5543_sched;

   localparam int DW = 16;
   localparam int PW = 16;

   logic          clk;
   logic          rst;
   logic          en;
   logic [PW-1:0] period;
   logic          s0_tvalid, s0_tready, s1_tvalid, s1_tready;
   logic [DW-1:0] s0_tdata, s1_tdata;
   logic          m_tvalid, m_tready;
   logic [DW-1:0] m_tdata;
   logic          grant_id, underrun, overrun;

   ad5543_sched #(.DW(DW), .PW(PW)) dut (
      .s_axis_aclk    (clk),
      .s_axis_areset  (rst),
      .en             (en),
      .period         (period),
      .s0_axis_tvalid (s0_tvalid),
      .s0_axis_tready (s0_tready),
      .s0_axis_tdata  (s0_tdata),
      .s1_axis_tvalid (s1_tvalid),
      .s1_axis_tready (s1_tready),
      .s1_axis_tdata  (s1_tdata),
      .m_axis_tvalid  (m_tvalid),
      .m_axis_tready  (m_tready),
      .m_axis_tdata   (m_tdata),
      .grant_id       (grant_id),
      .underrun       (underrun),
      .overrun        (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   logic [16:0] sb[$];          // {grant_id, tdata}
   int exp_period = 1;
   int last_hs    = -1;
   int first_vld  = -1;
   int n_under = 0, n_vld = 0, n_src_hs = 0;
   logic          stall = 1'b0;
   logic [DW-1:0] stall_dat = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor: scoreboard pop on handshake, pacing, stall stability, pulse counts
   initial forever begin
      logic [16:0] e;
      @(negedge clk);
      if (rst) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_tvalid", m_tvalid, 1);
            check("stall_tdata", m_tdata, stall_dat);
         end
         if (m_tvalid && first_vld < 0) first_vld = cyc;
         if (m_tvalid) n_vld++;
         if (underrun) n_under++;
         if ((s0_tvalid && s0_tready) || (s1_tvalid && s1_tready)) n_src_hs++;
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               check("unexpected_xfer", 1, 0);
            end else begin
               e = sb.pop_front();
               check("tdata", m_tdata, e[15:0]);
               check("grant_id", grant_id, e[16]);
            end
            if (last_hs >= 0) check("xfer_interval", cyc - last_hs, exp_period);
            last_hs = cyc;
         end
         stall     = m_tvalid && !m_tready;
         stall_dat = m_tdata;
      end
   end

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; m_tready = 1'b0;
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tdata = '0; s1_tdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      last_hs = -1; first_vld = -1;
      sb.delete();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      #1;
      check({tag, "_drain"}, sb.size(), 0);
   endtask

   task automatic wait_vld(input string tag, input int budget);
      int i = 0;
      while (!m_tvalid && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(tag, m_tvalid, 1);
   endtask

   initial begin
      int c0, u0, v0, h0, ov, hs, vv, rr;
      period = 16'd1;
      do_reset();

      // reset state
      @(negedge clk);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_grant", grant_id, 0);
      check("rst_underrun", underrun, 0);
      check("rst_overrun", overrun, 0);
      check("rst_s0_tready", s0_tready, 0);
      check("rst_s1_tready", s1_tready, 0);

      // no source valid, period 5: underrun every tick
      do_reset();
      period = 16'd5; exp_period = 5; m_tready = 1'b1;
`ifdef AD5543_SCHED_REPEAT_EN
      for (int i = 0; i < 5; i++) sb.push_back({1'b0, 16'h0000});
`endif
      u0 = n_under; v0 = n_vld;
      @(posedge clk); #1 en = 1'b1;
      repeat (25) @(posedge clk);
      #1 en = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("t3_underruns", n_under - u0, 5);
`ifdef AD5543_SCHED_REPEAT_EN
      check("t3_repeat_left", sb.size(), 0);
`else
      check("t3_no_tvalid", n_vld - v0, 0);
`endif

      // single source, period 4
      do_reset();
      period = 16'd4; exp_period = 4; m_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 16'h1234;
      for (int i = 0; i < 4; i++) sb.push_back({1'b0, 16'h1234});
      @(posedge clk); #1 en = 1'b1; c0 = cyc;
      wait_drain("t1", 40);
      en = 1'b0;
      check("t1_latency", first_vld - c0, 5);

      // both sources valid, period 3: strict alternation starting with s0
      do_reset();
      period = 16'd3; exp_period = 3; m_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 16'hAAAA;
      s1_tvalid = 1'b1; s1_tdata = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         sb.push_back({1'b0, 16'hAAAA});
         sb.push_back({1'b1, 16'h5555});
      end
      @(posedge clk); #1 en = 1'b1; c0 = cyc;
      wait_drain("t2", 40);
      en = 1'b0;
      check("t2_latency", first_vld - c0, 4);

      // period 2 with tready held low 10 clocks: data stable, overrun every 2 clocks
      do_reset();
      period = 16'd2; exp_period = 2; m_tready = 1'b0;
      s0_tvalid = 1'b1; s0_tdata = 16'hBEEF;
      sb.push_back({1'b0, 16'hBEEF});
      h0 = n_src_hs;
      @(posedge clk); #1 en = 1'b1;
      wait_vld("t4_vld", 20);
      ov = 0; hs = 0;
      repeat (10) begin
         @(negedge clk);
         if (overrun) ov++;
         if (s0_tvalid && s0_tready) hs++;
      end
      check("t4_overruns", ov, 5);
      check("t4_stall_src_hs", hs, 0);
      @(posedge clk); #1 m_tready = 1'b1; en = 1'b0; s0_tvalid = 1'b0;
      wait_drain("t4", 10);
      check("t4_total_src_hs", n_src_hs - h0, 1);

      // en dropped during SEND: transfer completes, then everything goes quiet
      do_reset();
      period = 16'd4; exp_period = 4; m_tready = 1'b0;
      s0_tvalid = 1'b1; s0_tdata = 16'h0F0F;
      sb.push_back({1'b0, 16'h0F0F});
      @(posedge clk); #1 en = 1'b1;
      wait_vld("t5_vld", 20);
      @(posedge clk); #1 en = 1'b0;
      repeat (3) @(posedge clk);
      #1 m_tready = 1'b1;
      wait_drain("t5", 10);
      vv = 0; rr = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_tvalid) vv++;
         if (s0_tready || s1_tready) rr++;
      end
      check("t5_quiet_tvalid", vv, 0);
      check("t5_quiet_tready", rr, 0);

      // reset asserted mid-SEND
      do_reset();
      period = 16'd3; exp_period = 3; m_tready = 1'b0;
      s1_tvalid = 1'b1; s1_tdata = 16'h7777;
      @(posedge clk); #1 en = 1'b1;
      wait_vld("t6_vld", 20);
      check("t6_gid_pre", grant_id, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      s0_tvalid = 1'b1; s0_tdata = 16'hAAAA; s1_tdata = 16'h5555; m_tready = 1'b1;
      @(negedge clk);
      check("t6_rst_tvalid", m_tvalid, 0);
      check("t6_rst_grant", grant_id, 0);
      check("t6_rst_cnt", dut.cnt, 0);
      last_hs = -1; sb.delete();
      sb.push_back({1'b0, 16'hAAAA});
      @(posedge clk); #1 rst = 1'b0;
      wait_drain("t6", 20);
      en = 1'b0;

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
